// File: rtl/ssd_frame_capture.sv
// ssd_frame_capture: rebuilds eight hex digits, decimal points and blank flags from a
// scanned, active-low seven-segment bus. Define SSD_FRAME_CAPTURE_SYNC_EN for a 2-flop input synchronizer.
module ssd_frame_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLOCK_100,
  input  logic        reset,
  input  logic [3:0]  D2_AN,
  input  logic [3:0]  D1_AN,
  input  logic [7:0]  D2_SEG,
  input  logic [7:0]  D1_SEG,
  output logic [31:0] digits,
  output logic [7:0]  dec_points,
  output logic [7:0]  blank,
  output logic [7:0]  invalid,
  output logic        frame_valid,
  output logic        frame_strobe
);

  typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} state_t;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_MAX  = 32'(TIMEOUT_CYCLES);

  logic [23:0] raw;
  logic [23:0] samp;
  logic [19:0] prev;

`ifdef SSD_FRAME_CAPTURE_SYNC_EN
  logic [23:0] sync1;
  logic [23:0] sync2;

  // Idle-bus value (anodes off, segments dark) keeps the reader in IDLE during reset.
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      sync1 <= 24'hFF_FFFF;
      sync2 <= 24'hFF_FFFF;
    end else begin
      sync1 <= {D2_AN, D1_AN, D2_SEG, D1_SEG};
      sync2 <= sync1;
    end
  end

  assign raw = sync2;
`else
  assign raw = {D2_AN, D1_AN, D2_SEG, D1_SEG};
`endif

  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      samp <= 24'hFF_FFFF;
      prev <= 20'hF_FFFF;
    end else begin
      samp <= raw;
      prev <= {samp[23:20], samp[15:0]};
    end
  end

  logic [3:0] an_lo;
  logic [3:0] an_hi;
  logic [7:0] seg_lo;
  logic [7:0] seg_hi;
  logic       legal;
  logic [1:0] idx;
  logic       same;

  assign an_lo  = samp[23:20];
  assign an_hi  = samp[19:16];
  assign seg_lo = samp[15:8];
  assign seg_hi = samp[7:0];
  assign same   = ({an_lo, seg_lo, seg_hi} == prev);

  always_comb begin
    legal = 1'b0;
    idx   = 2'd0;
    if (an_lo == an_hi) begin
      case (an_lo)
        4'b1110: begin legal = 1'b1; idx = 2'd0; end
        4'b1101: begin legal = 1'b1; idx = 2'd1; end
        4'b1011: begin legal = 1'b1; idx = 2'd2; end
        4'b0111: begin legal = 1'b1; idx = 2'd3; end
        default: ;
      endcase
    end
  end

  // Packed result: {invalid, blank, dp, nibble}.
  function automatic logic [6:0] decode_seg(input logic [7:0] seg);
    logic [3:0] nib;
    logic       bad;
    nib = 4'h0;
    bad = 1'b0;
    case (seg[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: bad = 1'b1;
    endcase
    if (seg == 8'hFF) return 7'b010_0000;
    return {bad, 1'b0, ~seg[7], nib};
  endfunction

  state_t      state;
  state_t      state_n;
  logic [15:0] count;
  logic [15:0] count_n;
  logic        capture;
  logic        commit;
  logic        timeout_hit;
  logic [3:0]  mask;
  logic [3:0]  mask_set;
  logic [31:0] tmo_cnt;

  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 16'd0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      IDLE: begin
        count_n = 16'd0;
        if (legal) begin
          state_n = SETTLING;
          count_n = 16'd1;
        end
      end
      SETTLING: begin
        if (!legal) begin
          state_n = IDLE;
          count_n = 16'd0;
        end else if (!same) begin
          count_n = 16'd1;
        end else if (capture) begin
          state_n = CAPTURED;
          count_n = count + 16'd1;
        end else begin
          count_n = count + 16'd1;
        end
      end
      CAPTURED: begin
        if (!legal) begin
          state_n = IDLE;
          count_n = 16'd0;
        end else if (!same) begin
          state_n = SETTLING;
          count_n = 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 16'd0;
      end
    endcase
  end

  always_comb begin
    capture     = (state == SETTLING) && legal && same && (count == SETTLE_LAST);
    mask_set    = mask | (4'b0001 << idx);
    commit      = capture && (mask_set == 4'hF);
    timeout_hit = !capture && (tmo_cnt == TIMEOUT_LAST);
  end

  logic [6:0]      dec_lo;
  logic [6:0]      dec_hi;
  logic [7:0][3:0] sh_digit;
  logic [7:0][3:0] sh_digit_n;
  logic [7:0]      sh_dp;
  logic [7:0]      sh_dp_n;
  logic [7:0]      sh_blank;
  logic [7:0]      sh_blank_n;
  logic [7:0]      sh_inv;
  logic [7:0]      sh_inv_n;

  assign dec_lo = decode_seg(seg_lo);
  assign dec_hi = decode_seg(seg_hi);

  // The low bank lands in digit idx, the high bank in digit idx+4.
  always_comb begin
    sh_digit_n = sh_digit;
    sh_dp_n    = sh_dp;
    sh_blank_n = sh_blank;
    sh_inv_n   = sh_inv;
    if (capture) begin
      sh_digit_n[{1'b0, idx}] = dec_lo[3:0];
      sh_dp_n[{1'b0, idx}]    = dec_lo[4];
      sh_blank_n[{1'b0, idx}] = dec_lo[5];
      sh_inv_n[{1'b0, idx}]   = dec_lo[6];
      sh_digit_n[{1'b1, idx}] = dec_hi[3:0];
      sh_dp_n[{1'b1, idx}]    = dec_hi[4];
      sh_blank_n[{1'b1, idx}] = dec_hi[5];
      sh_inv_n[{1'b1, idx}]   = dec_hi[6];
    end
  end

  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      sh_digit <= '0;
      sh_dp    <= 8'h00;
      sh_blank <= 8'hFF;
      sh_inv   <= 8'h00;
      tmo_cnt  <= 32'd0;
    end else begin
      sh_digit <= sh_digit_n;
      sh_dp    <= sh_dp_n;
      sh_blank <= sh_blank_n;
      sh_inv   <= sh_inv_n;
      if (capture) tmo_cnt <= 32'd0;
      else if (tmo_cnt != TIMEOUT_MAX) tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // Commit takes the shadow including the digit captured on the same edge.
  always_ff @(posedge CLOCK_100 or posedge reset) begin
    if (reset) begin
      mask         <= 4'h0;
      digits       <= 32'd0;
      dec_points   <= 8'h00;
      blank        <= 8'hFF;
      invalid      <= 8'h00;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= commit;
      if (commit) begin
        mask        <= 4'h0;
        digits      <= sh_digit_n;
        dec_points  <= sh_dp_n;
        blank       <= sh_blank_n;
        invalid     <= sh_inv_n;
        frame_valid <= 1'b1;
      end else if (capture) begin
        mask <= mask_set;
      end else if (timeout_hit) begin
        mask        <= 4'h0;
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssd_frame_capture.sv
// tb_ssd_frame_capture: directed scans of the seven-segment bus with hand-computed
// frames, covering glitches, anode mismatch, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_ssd_frame_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 200;
  localparam int DWELL   = 40;

  logic        CLOCK_100 = 1'b0;
  logic        reset;
  logic [3:0]  D2_AN;
  logic [3:0]  D1_AN;
  logic [7:0]  D2_SEG;
  logic [7:0]  D1_SEG;
  logic [31:0] digits;
  logic [7:0]  dec_points;
  logic [7:0]  blank;
  logic [7:0]  invalid;
  logic        frame_valid;
  logic        frame_strobe;

  int checkCount      = 0;
  int failCount       = 0;
  int cycleNum        = 0;
  int strobeCount     = 0;
  int lastStrobeCycle = 0;
  int fvFallCycle     = 0;
  int idx3Start       = 0;
  int s0              = 0;
  logic lastFv        = 1'b0;
  logic [7:0] frameSeg [8];

  always #5 CLOCK_100 = ~CLOCK_100;

  ssd_frame_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLOCK_100(CLOCK_100), .reset(reset),
    .D2_AN(D2_AN), .D1_AN(D1_AN), .D2_SEG(D2_SEG), .D1_SEG(D1_SEG),
    .digits(digits), .dec_points(dec_points), .blank(blank), .invalid(invalid),
    .frame_valid(frame_valid), .frame_strobe(frame_strobe)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Every cycle is observed on the falling edge, away from the capturing edge.
  task automatic tick();
    @(negedge CLOCK_100);
    cycleNum++;
    if (frame_strobe) begin
      strobeCount++;
      lastStrobeCycle = cycleNum;
    end
    if (lastFv && !frame_valid) fvFallCycle = cycleNum;
    lastFv = frame_valid;
  endtask

  function automatic logic [7:0] hexSeg(input logic [3:0] n, input logic dp);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40; 4'h1: p = 7'h79; 4'h2: p = 7'h24; 4'h3: p = 7'h30;
      4'h4: p = 7'h19; 4'h5: p = 7'h12; 4'h6: p = 7'h02; 4'h7: p = 7'h78;
      4'h8: p = 7'h00; 4'h9: p = 7'h18; 4'hA: p = 7'h08; 4'hB: p = 7'h03;
      4'hC: p = 7'h46; 4'hD: p = 7'h21; 4'hE: p = 7'h06; default: p = 7'h0E;
    endcase
    return {~dp, p};
  endfunction

  function automatic logic [3:0] anodeOf(input int k);
    return 4'(~(4'b0001 << k));
  endfunction

  task automatic applyStimulus(input logic [3:0] an2, input logic [3:0] an1,
                               input logic [7:0] seg2, input logic [7:0] seg1, input int cycles);
    D2_AN  = an2;
    D1_AN  = an1;
    D2_SEG = seg2;
    D1_SEG = seg1;
    repeat (cycles) tick();
  endtask

  task automatic loadFrame(input logic [31:0] nib, input logic [7:0] dps, input logic [7:0] blanks);
    for (int i = 0; i < 8; i++)
      frameSeg[i] = blanks[i] ? 8'hFF : hexSeg(nib[4*i +: 4], dps[i]);
  endtask

  task automatic showIndex(input int k);
    applyStimulus(anodeOf(k), anodeOf(k), frameSeg[k], frameSeg[k+4], DWELL);
  endtask

  task automatic scanFrame(input int glitch);
    for (int k = 0; k < 4; k++) begin
      if (glitch > 0)
        applyStimulus(anodeOf(k), anodeOf(k), hexSeg(4'hE, 1'b0), hexSeg(4'hE, 1'b0), glitch);
      if (k == 3) idx3Start = cycleNum;
      showIndex(k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(4'hF, 4'hF, 8'hFF, 8'hFF, 3);
    checkOutput("rst_digits", digits, 32'd0);
    checkOutput("rst_dp", {24'd0, dec_points}, 32'h00);
    checkOutput("rst_blank", {24'd0, blank}, 32'hFF);
    checkOutput("rst_invalid", {24'd0, invalid}, 32'h00);
    checkOutput("rst_fv", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_strobe", {31'd0, frame_strobe}, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Plain frame 8..1, with first-commit latency.
    loadFrame(32'h87654321, 8'h00, 8'h00);
    s0 = strobeCount;
    scanFrame(0);
    checkOutput("f1_strobes", 32'(strobeCount - s0), 32'd1);
    checkOutput("f1_latency", 32'(lastStrobeCycle - idx3Start), 32'(SETTLE + 1));
    checkOutput("f1_digits", digits, 32'h87654321);
    checkOutput("f1_blank", {24'd0, blank}, 32'h00);
    checkOutput("f1_invalid", {24'd0, invalid}, 32'h00);
    checkOutput("f1_dp", {24'd0, dec_points}, 32'h00);
    checkOutput("f1_fv", {31'd0, frame_valid}, 32'd1);

    // Scanning stops: frame_valid must fall exactly TIMEOUT cycles after last capture.
    s0 = strobeCount;
    fvFallCycle = 0;
    applyStimulus(4'hF, 4'hF, 8'hFF, 8'hFF, TIMEOUT + 20);
    checkOutput("tmo_delay", 32'(fvFallCycle - lastStrobeCycle), 32'(TIMEOUT));
    checkOutput("tmo_fv", {31'd0, frame_valid}, 32'd0);
    checkOutput("tmo_digits", digits, 32'h87654321);
    checkOutput("tmo_strobes", 32'(strobeCount - s0), 32'd0);

    // Decimal points on digits 0 and 7, digit 5 blank.
    loadFrame(32'h87054321, 8'h81, 8'h20);
    s0 = strobeCount;
    scanFrame(0);
    checkOutput("f2_strobes", 32'(strobeCount - s0), 32'd1);
    checkOutput("f2_dp", {24'd0, dec_points}, 32'h81);
    checkOutput("f2_blank", {24'd0, blank}, 32'h20);
    checkOutput("f2_digits", digits, 32'h87054321);
    checkOutput("f2_fv", {31'd0, frame_valid}, 32'd1);

    // Dp-only glyph on digit 2 is illegal; digit 6 blank.
    loadFrame(32'h87654321, 8'h00, 8'h00);
    frameSeg[2] = 8'h7F;
    frameSeg[6] = 8'hFF;
    s0 = strobeCount;
    scanFrame(0);
    checkOutput("f3_strobes", 32'(strobeCount - s0), 32'd1);
    checkOutput("f3_invalid", {24'd0, invalid}, 32'h04);
    checkOutput("f3_dp", {24'd0, dec_points}, 32'h04);
    checkOutput("f3_blank", {24'd0, blank}, 32'h40);
    checkOutput("f3_digits", digits, 32'h80654021);

    // 10-cycle wrong pattern at the start of every dwell must never land.
    loadFrame(32'h87654321, 8'h00, 8'h00);
    s0 = strobeCount;
    scanFrame(10);
    checkOutput("gl_strobes", 32'(strobeCount - s0), 32'd1);
    checkOutput("gl_digits", digits, 32'h87654321);
    checkOutput("gl_invalid", {24'd0, invalid}, 32'h00);
    checkOutput("gl_blank", {24'd0, blank}, 32'h00);

    // Anode mismatch: long hold never captures, short burst restarts settling.
    loadFrame(32'h13572468, 8'h10, 8'h00);
    s0 = strobeCount;
    for (int k = 0; k < 3; k++) showIndex(k);
    applyStimulus(anodeOf(3), anodeOf(0), frameSeg[3], frameSeg[7], DWELL);
    checkOutput("mm_hold_strobes", 32'(strobeCount - s0), 32'd0);
    applyStimulus(anodeOf(3), anodeOf(3), frameSeg[3], frameSeg[7], 10);
    applyStimulus(anodeOf(3), anodeOf(0), frameSeg[3], frameSeg[7], 3);
    idx3Start = cycleNum;
    showIndex(3);
    checkOutput("mm_strobes", 32'(strobeCount - s0), 32'd1);
    checkOutput("mm_latency", 32'(lastStrobeCycle - idx3Start), 32'(SETTLE + 1));
    checkOutput("mm_digits", digits, 32'h13572468);
    checkOutput("mm_dp", {24'd0, dec_points}, 32'h10);

    // Reset after three indices: partial frame is discarded.
    loadFrame(32'h87654321, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) showIndex(k);
    s0 = strobeCount;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("mr_blank", {24'd0, blank}, 32'hFF);
    checkOutput("mr_digits", digits, 32'd0);
    checkOutput("mr_fv", {31'd0, frame_valid}, 32'd0);
    loadFrame(32'hFEDCBA90, 8'h0F, 8'h00);
    showIndex(3);
    showIndex(0);
    showIndex(1);
    checkOutput("mr_partial_strobes", 32'(strobeCount - s0), 32'd0);
    checkOutput("mr_partial_blank", {24'd0, blank}, 32'hFF);
    showIndex(2);
    checkOutput("mr_strobes", 32'(strobeCount - s0), 32'd1);
    checkOutput("mr_new_digits", digits, 32'hFEDCBA90);
    checkOutput("mr_new_dp", {24'd0, dec_points}, 32'h0F);
    checkOutput("mr_new_blank", {24'd0, blank}, 32'h00);
    checkOutput("mr_new_fv", {31'd0, frame_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
